// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM for the multicycle FRiscV core. Each RV32I instruction runs
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). Instruction and data
// memories may add wait states. A request that waits too long for ready sends
// the FSM to a sticky ERROR state.
//
// Optional feature macro: FRISCV_ILLEGAL_TRAP_EN
//   undefined : unknown opcodes and branch func3 2/3 retire as NOPs.
//   defined   : those instructions enter TRAP. TRAP pulses illegal_out for one
//               cycle and then goes to ERROR.
//
// Ports
//   clk_in, rst_n_in       clock, synchronous active-low reset
//   instr_in               instruction word (latched when ir_write_out=1)
//   zero_in, lt_in         ALU flags, used in EXEC for branches
//   imem_ready_in          instruction memory data valid
//   dmem_ready_in          data memory access complete
//   imem_req_out           instruction fetch request
//   dmem_req_out           data memory request
//   mem_write_out          marks the data request as a store
//   ir_write_out           IR load strobe
//   pc_write_out           PC update strobe
//   pc_src_out             0 = PC+4, 1 = branch/jump target
//   jump_src_out           1 = target comes from the ALU (JALR)
//   reg_write_out          register file write enable
//   alu_src_out            1 = immediate drives ALU operand B
//   auipc_out              1 = PC drives ALU operand A
//   alu_ctrl_out           ALU operation
//   result_src_out         00 ALU, 01 memory, 10 PC+4 / PC+imm
//   retire_out             one-cycle pulse per completed instruction
//   err_out                sticky bus-timeout / trap error
//   illegal_out            (macro only) one-cycle illegal-instruction pulse
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_CNT_W   = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [31:0]           instr_in,
  input  logic                  zero_in,
  input  logic                  lt_in,
  input  logic                  imem_ready_in,
  input  logic                  dmem_ready_in,
  output logic                  imem_req_out,
  output logic                  dmem_req_out,
  output logic                  mem_write_out,
  output logic                  ir_write_out,
  output logic                  pc_write_out,
  output logic                  pc_src_out,
  output logic                  jump_src_out,
  output logic                  reg_write_out,
  output logic                  alu_src_out,
  output logic                  auipc_out,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_out,
  output logic [1:0]            result_src_out,
  output logic                  retire_out,
  output logic                  err_out
`ifdef FRISCV_ILLEGAL_TRAP_EN
  ,
  output logic                  illegal_out
`endif
);

  // RV32I major opcodes
  localparam logic [6:0] OP_REG       = 7'b0110011;
  localparam logic [6:0] OP_IMM_ARITH = 7'b0010011;
  localparam logic [6:0] OP_IMM_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JUMP      = 7'b1101111;
  localparam logic [6:0] OP_IMM_JUMP  = 7'b1100111;
  localparam logic [6:0] OP_U_L_LOAD  = 7'b0110111;
  localparam logic [6:0] OP_U_AUIPC   = 7'b0010111;

  // ALU operation codes. These are the shared friscv_pkg ALU op values.
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLR  = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] ALU_SAR  = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(9);

  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR, S_TRAP
  } state_t;

  state_t               state_reg, state_next;
  logic [TMO_CNT_W-1:0] cnt_reg, cnt_next;
  logic [6:0]           opcode_reg;
  logic [2:0]           func3_reg;
  logic                 f7b5_reg;     // instr[30]: SUB / SAR select

  logic                    br_legal, br_taken;
  logic [ALU_CTRL_W-1:0]   br_op;

  // Only opcode, func3 and instr[30] control sequencing. The rest of the
  // word belongs to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_in[31], instr_in[29:15], instr_in[11:7]};

  // R-type and I-type arithmetic decode. Only R-type uses instr[30] for SUB,
  // because for ADDI that bit is part of the immediate.
  function automatic logic [ALU_CTRL_W-1:0] arith_op(input logic [2:0] f3,
                                                     input logic       alt,
                                                     input logic       is_reg);
    logic [ALU_CTRL_W-1:0] op;
    case (f3)
      3'd0:    op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SAR : ALU_SLR;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // State, timeout counter and latched instruction fields
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_reg  <= S_FETCH;
      cnt_reg    <= '0;
      opcode_reg <= '0;
      func3_reg  <= '0;
      f7b5_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (ir_write_out) begin
        opcode_reg <= instr_in[6:0];
        func3_reg  <= instr_in[14:12];
        f7b5_reg   <= instr_in[30];
      end
    end
  end

  // Branch condition. This is the only output path from the ALU flags.
  always_comb begin
    br_legal = 1'b1;
    br_taken = 1'b0;
    br_op    = ALU_SUB;
    case (func3_reg)
      3'd0: br_taken = zero_in;
      3'd1: br_taken = !zero_in;
      3'd4: begin br_op = ALU_SLT;  br_taken = lt_in;  end
      3'd5: begin br_op = ALU_SLT;  br_taken = !lt_in; end
      3'd6: begin br_op = ALU_SLTU; br_taken = lt_in;  end
      3'd7: begin br_op = ALU_SLTU; br_taken = !lt_in; end
      default: begin br_legal = 1'b0; br_op = ALU_ADD; end
    endcase
  end

  // Next state and outputs
  always_comb begin
    state_next     = state_reg;
    cnt_next       = '0;      // cleared whenever the FSM does not stay waiting
    imem_req_out   = 1'b0;
    dmem_req_out   = 1'b0;
    mem_write_out  = 1'b0;
    ir_write_out   = 1'b0;
    pc_write_out   = 1'b0;
    pc_src_out     = 1'b0;
    jump_src_out   = 1'b0;
    reg_write_out  = 1'b0;
    alu_src_out    = 1'b0;
    auipc_out      = 1'b0;
    alu_ctrl_out   = ALU_ADD;
    result_src_out = 2'b00;
    retire_out     = 1'b0;
    err_out        = 1'b0;
`ifdef FRISCV_ILLEGAL_TRAP_EN
    illegal_out    = 1'b0;
`endif

    case (state_reg)
      S_FETCH: begin
        imem_req_out = 1'b1;
        if (imem_ready_in) begin
          ir_write_out = 1'b1;
          state_next   = S_DECODE;
        end else if (cnt_reg == TMO_LIMIT) begin
          state_next = S_ERROR;   // ready at the limit still wins (branch above)
        end else begin
          cnt_next = cnt_reg + TMO_CNT_W'(1);
        end
      end

      S_DECODE: state_next = S_EXEC;

      S_EXEC: begin
        case (opcode_reg)
          OP_REG: begin
            alu_ctrl_out = arith_op(func3_reg, f7b5_reg, 1'b1);
            state_next   = S_WB;
          end
          OP_IMM_ARITH: begin
            alu_src_out  = 1'b1;
            alu_ctrl_out = arith_op(func3_reg, f7b5_reg, 1'b0);
            state_next   = S_WB;
          end
          OP_IMM_LOAD, OP_STORE: begin
            alu_src_out = 1'b1;
            state_next  = S_MEM;
          end
          OP_BRANCH: begin
            alu_ctrl_out = br_op;
`ifdef FRISCV_ILLEGAL_TRAP_EN
            if (!br_legal) begin
              state_next = S_TRAP;
            end else begin
              pc_write_out = 1'b1;
              retire_out   = 1'b1;
              pc_src_out   = br_taken;
              state_next   = S_FETCH;
            end
`else
            pc_write_out = 1'b1;
            retire_out   = 1'b1;
            pc_src_out   = br_legal && br_taken;
            state_next   = S_FETCH;
`endif
          end
          OP_JUMP, OP_IMM_JUMP: begin
            alu_src_out    = 1'b1;
            result_src_out = 2'b10;
            pc_src_out     = 1'b1;
            jump_src_out   = (opcode_reg == OP_IMM_JUMP);
            state_next     = S_WB;
          end
          OP_U_L_LOAD: begin
            alu_src_out = 1'b1;
            state_next  = S_WB;
          end
          OP_U_AUIPC: begin
            alu_src_out    = 1'b1;
            auipc_out      = 1'b1;
            result_src_out = 2'b10;
            state_next     = S_WB;
          end
          default: begin
`ifdef FRISCV_ILLEGAL_TRAP_EN
            state_next = S_TRAP;
`else
            pc_write_out = 1'b1;
            retire_out   = 1'b1;
            state_next   = S_FETCH;
`endif
          end
        endcase
      end

      S_MEM: begin
        dmem_req_out  = 1'b1;
        alu_src_out   = 1'b1;   // keep the address stable for the whole access
        mem_write_out = (opcode_reg == OP_STORE);
        if (dmem_ready_in) begin
          if (opcode_reg == OP_STORE) begin
            pc_write_out = 1'b1;
            retire_out   = 1'b1;
            state_next   = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (cnt_reg == TMO_LIMIT) begin
          state_next = S_ERROR;
        end else begin
          cnt_next = cnt_reg + TMO_CNT_W'(1);
        end
      end

      S_WB: begin
        reg_write_out = 1'b1;
        pc_write_out  = 1'b1;
        retire_out    = 1'b1;
        state_next    = S_FETCH;
        case (opcode_reg)
          OP_IMM_LOAD: result_src_out = 2'b01;
          OP_JUMP, OP_IMM_JUMP: begin
            // Hold the jump selects so the PC loads the target and rd gets PC+4.
            result_src_out = 2'b10;
            pc_src_out     = 1'b1;
            jump_src_out   = (opcode_reg == OP_IMM_JUMP);
          end
          OP_U_AUIPC: begin
            result_src_out = 2'b10;
            auipc_out      = 1'b1;
          end
          default: result_src_out = 2'b00;
        endcase
      end

      S_ERROR: err_out = 1'b1;   // left only through reset

`ifdef FRISCV_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_out = 1'b1;
        state_next  = S_ERROR;
      end
`endif

      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised successor to the single-cycle FRiscV main controller; sequences each RV32I instruction through a multicycle FSM (FETCH/DECODE/EXEC/MEM/WB).
- Drives the shared datapath and handshakes with instruction and data memories that may insert wait states.
- Adds bus-timeout error detection and a per-instruction retire pulse.
- Sits between the register file/ALU datapath and the memory interface; ALU op encodings are the friscv_pkg ALU operation constants.

Parameters:
- ALU_CTRL_W, 4, width of alu_ctrl_out; must hold every friscv_pkg ALU op.
- MEM_TIMEOUT, 16, maximum cycles a memory request may wait for ready before error; legal range 1..255.
- TMO_CNT_W, 8, width of the wait-state counter; must satisfy 2^TMO_CNT_W > MEM_TIMEOUT.

Ports:
- clk_in  in  1  clock; all state updates on the rising edge.
- rst_n_in  in  1  synchronous active-low reset.
- instr_in  in  32  instruction word; sampled only on the cycle ir_write_out=1.
- zero_in  in  1  ALU result zero; valid in EXEC.
- lt_in  in  1  ALU less-than; valid in EXEC.
- imem_ready_in  in  1  instruction memory data valid.
- dmem_ready_in  in  1  data memory access complete.
- imem_req_out  out  1  instruction fetch request.
- dmem_req_out  out  1  data memory request.
- mem_write_out  out  1  qualifies dmem_req_out as a store.
- ir_write_out  out  1  latch instr_in into the IR.
- pc_write_out  out  1  one-cycle PC update strobe.
- pc_src_out  out  1  0 = PC+4, 1 = branch/jump target.
- jump_src_out  out  1  1 = target taken from ALU (JALR).
- reg_write_out  out  1  register file write enable.
- alu_src_out  out  1  1 = immediate operand B.
- auipc_out  out  1  1 = operand A is PC.
- alu_ctrl_out  out  ALU_CTRL_W  ALU operation.
- result_src_out  out  2  00 = ALU, 01 = memory, 10 = PC+4 / PC+imm.
- retire_out  out  1  one-cycle pulse per completed instruction.
- err_out  out  1  sticky bus timeout error.

Behaviour:
- Reset (rst_n_in=0 at an edge): state=FETCH, timeout counter=0, err_out=0, IR copy=0. Every output is 0 except imem_req_out, which is 1 in the first cycle after reset. Reset mid-access aborts the access immediately, with no write strobe.
- Outputs are a Moore decode of the state register plus the latched opcode/func3/func7. Exception: pc_src_out in EXEC for branches is combinational on zero_in/lt_in.
- FETCH:
  - imem_req_out=1 held until imem_ready_in=1.
  - On ready: ir_write_out=1 in the same cycle, then DECODE.
  - Minimum latency is 1 cycle.
- DECODE: always 1 cycle; all strobes 0; then EXEC.
- EXEC (1 cycle), by opcode:
  - REG: ALU op per func3/func7[5] (ADD/SUB, SLL, SLT, SLTU, XOR, SLR/SAR, OR, AND). Go to WB.
  - IMM_ARITH: same ops with alu_src_out=1. func3=5 uses func7[5] (imm[10]) to select SAR vs SLR. Go to WB.
  - IMM_LOAD / STORE: ADD with alu_src_out=1. Go to MEM.
  - BRANCH:
    - beq/bne use SUB with zero_in; blt/bge use SLT with lt_in; bltu/bgeu use SLTU with lt_in.
    - pc_write_out=1, retire_out=1, pc_src_out=taken. Go to FETCH.
    - func3 2/3 are treated as not-taken.
  - JUMP / IMM_JUMP: ADD, alu_src_out=1, result_src_out=10, pc_src_out=1. IMM_JUMP also sets jump_src_out=1. Go to WB.
  - U_L_LOAD: alu_src_out=1. Go to WB.
  - U_AUIPC: alu_src_out=1, auipc_out=1, result_src_out=10. Go to WB.
  - Unknown opcode: treated as NOP with pc_write_out=1 and retire_out=1. Go to FETCH.
- MEM:
  - dmem_req_out=1 held until dmem_ready_in; mem_write_out=1 for STORE.
  - Load + ready: go to WB.
  - Store + ready: pc_write_out=1, retire_out=1, then FETCH.
- WB (1 cycle): reg_write_out=1, pc_write_out=1, retire_out=1, then FETCH. result_src_out=01 for loads; jump control signals are held from EXEC.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle that req=1 and ready=0.
  - When the counter reaches MEM_TIMEOUT with ready still 0, go to ERROR.
  - A ready arriving in the same cycle as the limit wins (no error).
- ERROR: all strobes and requests 0, err_out=1. Held until reset.
- Latency: ALU ops 4 cycles, branch 3, store 4, load 5, plus any wait states.

Optional Feature:
- Macro FRISCV_ILLEGAL_TRAP_EN.
- When defined:
  - Unknown opcodes, and branch func3 2/3, enter TRAP instead of being treated as NOP.
  - In TRAP: output illegal_out=1 (1 bit, extra port) for one cycle, no retire, pc_write_out=0, then ERROR.
- When undefined: NOP behaviour as above, and the illegal_out port is absent.

Test Plan:
- Reset release, ready tied to 1, then instr 0x002081B3 (add x3,x1,x2) → ir_write at cycle 1; EXEC alu_ctrl=ADD, alu_src=0; WB reg_write=1; retire at cycle 4.
- lw 0x0000A183 with dmem_ready delayed 3 cycles → dmem_req high for 4 cycles, result_src=01 in WB, retire at cycle 8.
- beq 0x00208463: zero_in=1 → pc_src=1, pc_write=1, no reg_write; repeat with zero_in=0 → pc_src=0.
- imem_ready held 0 with MEM_TIMEOUT=16 → ERROR after 16 wait cycles, err_out=1 sticky. Variant: ready on the 16th cycle → no error.
- sw 0x0020A023 with rst_n_in pulled low while in MEM → next cycle state=FETCH, dmem_req=0, mem_write=0, no retire.
- Opcode 0x7F: macro undefined → NOP retire in 3 cycles; macro defined → illegal_out pulse, then err_out=1.
